// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: boot vector and bubble-instruction defaults, word-align helper.
package fetch_stage_pkg;

    // Defaults shared with other stages so bubbles and boot address agree.
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST     = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Instruction fetch is word addressed; low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect/stall inputs, imem port and IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: id_stall from decode holds IF/ID; jump_flag from execute redirects.
// master = fetch stage; slave = surrounding pipeline (execute, decode, imem).
interface fetch_stage_if;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        id_stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        misalign_err;

    modport master (
        input  jump_flag, jump_target, id_stall, imem_rdata,
        output imem_addr, id_valid, id_pc, id_inst, misalign_err
    );

    modport slave (
        output jump_flag, jump_target, id_stall, imem_rdata,
        input  imem_addr, id_valid, id_pc, id_inst, misalign_err
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// Stall capture buffer for the IF/ID instruction word and the id_inst output mux.
// Latency: captures on the first stalled edge; output mux is combinational.
// Backpressure: while stalled the captured word is held; it clears on the next advance or flush.
// Ports: clk/rst_n, flush (redirect), stall, d_valid, imem_rdata in; id_inst out.
module fetch_hold_buf
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst
);

    logic        hold_valid;
    logic [31:0] hold_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_inst  <= 32'h0;
        end else if (flush) begin
            // The stalled instruction is being discarded by the redirect.
            hold_valid <= 1'b0;
        end else if (stall) begin
            // The synchronous memory output moves on after this edge, so grab
            // the IF/ID word exactly once, on the first stalled edge.
            if (!hold_valid && d_valid) begin
                hold_inst  <= imem_rdata;
                hold_valid <= 1'b1;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    assign id_inst = !d_valid   ? NOP_INST  :
                     hold_valid ? hold_inst : imem_rdata;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, drives sync imem, feeds the IF/ID register.
// Latency: first valid instruction one cycle after reset release; 1 instr/cycle steady state; redirect costs one bubble.
// Backpressure: id_stall holds PC and IF/ID (word captured in fetch_hold_buf); jump_flag overrides id_stall.
// Ports: clk, rst_n (async active-low), bus (fetch_stage_if.master: jump/stall in, imem port, IF/ID out, misalign_err).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] NOP_INST     = DEF_NOP_INST
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic        d_valid;
    logic        misalign;

    // Priority: redirect, then stall, then advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc     <= RESET_VECTOR;
            d_pc     <= 32'h0;
            d_valid  <= 1'b0;
            misalign <= 1'b0;
        end else if (bus.jump_flag) begin
            // Fetch continues at the aligned address; misalignment is only flagged.
            f_pc     <= align_word(bus.jump_target);
            d_valid  <= 1'b0;
            misalign <= misalign | (|bus.jump_target[1:0]);
        end else if (!bus.id_stall) begin
            d_pc    <= f_pc;
            d_valid <= 1'b1;
            f_pc    <= f_pc + PC_STEP; // wraps silently at 2^32
        end
    end

    fetch_hold_buf #(
        .NOP_INST (NOP_INST)
    ) u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.jump_flag),
        .stall      (bus.id_stall),
        .d_valid    (d_valid),
        .imem_rdata (bus.imem_rdata),
        .id_inst    (bus.id_inst)
    );

    assign bus.imem_addr    = f_pc;
    assign bus.id_valid     = d_valid;
    assign bus.id_pc        = d_pc;
    assign bus.misalign_err = misalign;

endmodule
